// File: rtl/mhsa_host_loader.sv
// mhsa_host_loader: host-side command engine driving the MHSA wrapper SRAM and control port.
// Ports: cmd_* command channel, in_* LOAD stream, out_* READ stream, soc_* SRAM port,
//        start/input_base/output_base/done accelerator control, busy/err status.
module mhsa_host_loader #(
  parameter int          WIDTH       = 64,
  parameter int          LEN_W       = 16,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0000_4000,
  parameter int          TIMEOUT_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_aux,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err,
  output logic             soc_write_en,
  output logic [WIDTH-1:0] soc_data_in,
  output logic [31:0]      soc_addr,
  input  logic [WIDTH-1:0] soc_data_out,
  output logic             start,
  output logic [31:0]      input_base,
  output logic [31:0]      output_base,
  input  logic             done
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, READ} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr, soc_addr_q;
  logic [LEN_W-1:0] rem, pop_rem;
  logic [TW-1:0]    tmo, tmo_nxt;
  logic [WIDTH-1:0] fifo [2];
  logic             wp, rp, inflight;
  logic [1:0]       cnt;
  logic             accept, bad, range_bad;
  logic             issue, pop, err_set;

  assign cmd_ready   = rst_n && (state == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign range_bad   = (33'(cmd_addr) + 33'(cmd_len)) > 33'(ADDR_LIMIT);
  assign bad         = (cmd_op == 2'd3) ||
                       ((cmd_op != 2'd1) && ((cmd_len == '0) || range_bad));
  assign busy        = (state != IDLE);
  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == READ) && (cnt != 2'd0);
  assign out_data    = fifo[rp];
  assign pop         = out_valid && out_ready;
  assign soc_data_in = soc_write_en ? in_data : '0;
  assign tmo_nxt     = tmo + TW'(1);

  // First READ word is issued in the accept cycle so data lands
  // two cycles after accept. A pop in the same cycle frees a slot.
  always_comb begin
    state_nxt    = state;
    soc_write_en = 1'b0;
    soc_addr     = soc_addr_q;
    issue        = 1'b0;
    err_set      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            err_set = 1'b1;
          end else begin
            case (cmd_op)
              2'd0: state_nxt = LOAD;
              2'd1: state_nxt = RUN;
              default: begin
                state_nxt = READ;
                issue     = 1'b1;
                soc_addr  = cmd_addr;
              end
            endcase
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          soc_write_en = 1'b1;
          soc_addr     = addr;
          if (rem == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      RUN: begin
        soc_addr = '0;
        if (done) begin
          state_nxt = IDLE;
        end else if (tmo_nxt == TMO_MAX) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      READ: begin
        issue = (rem != '0) &&
                (({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
        if (issue) soc_addr = addr;
        if (pop && (pop_rem == LEN_W'(1))) state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr        <= '0;
      soc_addr_q  <= '0;
      rem         <= '0;
      pop_rem     <= '0;
      tmo         <= '0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      inflight    <= 1'b0;
      cnt         <= '0;
      start       <= 1'b0;
      input_base  <= '0;
      output_base <= '0;
      err         <= 1'b0;
    end else begin
      soc_addr_q <= soc_addr;
      err        <= err_set;
      inflight   <= issue;
      if ((state == IDLE) && accept && !bad) begin
        tmo     <= '0;
        pop_rem <= cmd_len;
        if (cmd_op == 2'd2) begin
          addr <= cmd_addr + 32'd1;
          rem  <= cmd_len - LEN_W'(1);
        end else begin
          addr <= cmd_addr;
          rem  <= cmd_len;
        end
        if (cmd_op == 2'd1) begin
          start       <= 1'b1;
          input_base  <= cmd_addr;
          output_base <= cmd_aux;
        end
      end
      if (soc_write_en || ((state == READ) && issue)) begin
        addr <= addr + 32'd1;
        rem  <= rem - LEN_W'(1);
      end
      if (state == RUN) begin
        tmo <= tmo_nxt;
        if (state_nxt == IDLE) start <= 1'b0;
      end
      if (inflight) begin
        fifo[wp] <= soc_data_out;
        wp       <= ~wp;
      end
      if (pop) begin
        rp      <= ~rp;
        pop_rem <= pop_rem - LEN_W'(1);
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
